// File: rtl/regfile_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared register-file types and constants for the write-back path.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int REG_AW   = 3;
    localparam int REG_DW   = 32;
    localparam int IMM_W    = 8;
    localparam int NUM_REGS = 8;

    typedef struct packed {
        logic              imm;
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_req_t;

    localparam int WB_ALU  = 0;
    localparam int WB_LOAD = 1;
    localparam int WB_IMM  = 2;

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : N-way one-hot arbiter. Round-robin when RR_ARB_EN is defined,
//            otherwise fixed priority (lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_update,
    output logic [N-1:0] o_grant
);

`ifdef RR_ARB_EN
    localparam int            PW          = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] c_last_rst  = PW'(N - 1);

    logic [PW-1:0] r_last;
    logic [PW-1:0] w_next;
    logic          w_found;

    // Search order begins one past the most recent winner.
    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!w_found && i_req[i] && (((int'(r_last) + k) % N) == i)) begin
                    o_grant[i] = 1'b1;
                    w_found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_next = r_last;
        for (int i = 0; i < N; i++) begin
            if (o_grant[i]) begin
                w_next = PW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= c_last_rst;
        end else if (i_update) begin
            r_last <= w_next;
        end
    end
`else
    logic w_found;
    logic w_unused_ok;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && i_req[i]) begin
                o_grant[i] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

    assign w_unused_ok = ^{clk, rst, i_update};
`endif

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Shares the register-file write port among NREQ requesters via a
//            one-entry output stage. RR_ARB_EN selects round-robin arbitration.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = REG_AW,
    parameter int DW   = REG_DW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*DW-1:0]  req_data,
    input  logic [NREQ-1:0]     req_imm,
    input  logic                rf_hold,
    output logic                rf_we3,
    output logic                rf_rwe2,
    output logic [AW-1:0]       rf_a3,
    output logic [DW-1:0]       rf_wd3,
    output logic [IMM_W-1:0]    rf_i2,
    output logic [2**AW-1:0]    pending
);

    logic [NREQ-1:0] w_grant;
    logic            w_can_load;
    logic            w_xfer;
    logic            w_load;
    logic            w_sel_imm;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;

    logic            r_vld;
    logic            r_imm;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_data;

    rr_arbiter #(
        .N        (NREQ)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (req_valid),
        .i_update (w_xfer),
        .o_grant  (w_grant)
    );

    // Stage accepts when empty or when its current entry commits this cycle.
    assign w_can_load = ~r_vld | ~rf_hold;
    assign req_ready  = w_grant & {NREQ{w_can_load}};
    assign w_xfer     = |req_ready;
    assign w_load     = w_xfer && (w_sel_addr != '0);

    always_comb begin
        w_sel_imm  = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_imm  = w_sel_imm  | req_imm[i];
                w_sel_addr = w_sel_addr | req_addr[i*AW +: AW];
                w_sel_data = w_sel_data | req_data[i*DW +: DW];
            end
        end
    end

    // Fields are cleared on drain so the write bus idles at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld  <= 1'b0;
            r_imm  <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_load) begin
            r_vld  <= 1'b1;
            r_imm  <= w_sel_imm;
            r_addr <= w_sel_addr;
            r_data <= w_sel_data;
        end else if (r_vld && !rf_hold) begin
            r_vld  <= 1'b0;
            r_imm  <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end
    end

    assign rf_we3  = r_vld & ~r_imm & ~rf_hold;
    assign rf_rwe2 = r_vld &  r_imm & ~rf_hold;
    assign rf_a3   = r_addr;
    assign rf_wd3  = r_data;
    assign rf_i2   = r_data[IMM_W-1:0];

    always_comb begin
        pending = '0;
        if (r_vld) begin
            pending[r_addr] = 1'b1;
        end
    end

endmodule
`default_nettype wire
